pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 64: operand/result width in bits.
REQ-002 Parameter STAGES, default 4: pipeline depth; each stage adds one WIDTH/STAGES-bit slice.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands and op present.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBB.
REQ-010 cin  input  1  carry/borrow-in, used by ADC/SBB only.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  WIDTH  result.
REQ-014 carry_out  output  1  carry out of the MSB (unsigned carry; for SUB/SBB 1 = no borrow).
REQ-015 overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-016 Input transfer SHALL occur on in_valid&&in_ready; output transfer on out_valid&&out_ready.
REQ-017 ADD: a+b+0; ADC: a+b+cin; SUB: a+~b+1; SBB: a+~b+cin, all modulo 2^WIDTH.
REQ-018 Stage k (1..STAGES) SHALL compute slice k-1 (bits k*W/S-1 : (k-1)*W/S), consuming carry registered by stage k-1; unprocessed upper operand bits and lower result bits travel with the token.
REQ-019 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with out_ready held high; throughput one result per cycle.
REQ-020 Each stage holds a valid bit; stage advances when next stage is empty or advancing; output stage holds its contents and out_valid while out_valid&&!out_ready.
REQ-021 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing), combinationally; no bubble is inserted under continuous flow.
REQ-022 Simultaneous input and output transfer with a full pipeline SHALL lose and duplicate no token.
REQ-023 Results SHALL leave in acceptance order; out, carry_out, overflow stable while held.
REQ-024 Data registers MAY be non-reset; valid bits SHALL be reset.
REQ-025 Elaboration SHALL fail if WIDTH % STAGES != 0 or STAGES < 1 or STAGES > WIDTH.

Reset
REQ-026 reset_n low SHALL asynchronously clear all valid bits; out_valid=0 immediately; in_ready=1 after release.
REQ-027 out, carry_out, overflow SHALL read 0 during reset.
REQ-028 Reset mid-operation SHALL discard all in-flight tokens; no result emitted for them after release.

Structure
REQ-029 Package adder_pkg SHALL hold op encodings (OP_ADD, OP_ADC, OP_SUB, OP_SBB) and the op typedef.
REQ-030 Sub-module adder_slice (combinational, parameter SLICE_W: a, b, cin -> sum, cout, c_msb) SHALL be instantiated once per stage.
REQ-031 STAGES=1 SHALL yield a single registered full-width adder.

Verification (WIDTH=64, STAGES=4 unless stated)
REQ-032 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> out=0, carry_out=1, overflow=0, out_valid exactly 4 cycles after transfer.
REQ-033 SUB a=0x8000_0000_0000_0000, b=1 -> out=0x7FFF_FFFF_FFFF_FFFF, carry_out=1, overflow=1; SBB a=5,b=7,cin=0 -> out=0xFFFF_FFFF_FFFF_FFFD, carry_out=0.
REQ-034 100 random back-to-back transfers, out_ready=1 -> in_ready constant 1, 100 results in order matching model.
REQ-035 Fill pipeline, drop out_ready 10 cycles -> in_ready=0 after 4 held tokens beyond output, output value constant; resume -> all tokens delivered in order, none lost.
REQ-036 Assert reset_n low with 3 tokens in flight -> out_valid=0 same cycle; after release no stale result appears within 10 cycles.
REQ-037 STAGES=1 and STAGES=8 (WIDTH=64): ADC a=0x0000_0000_FFFF_FFFF, b=0, cin=1 -> out=0x0000_0001_0000_0000, latency 1 and 8 respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// Operation encodings and decode helpers for the pipelined adder.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBB = 2'b11
  } op_t;

  // Subtraction is a + ~b + carry, so SUB/SBB feed the inverted operand.
  function automatic logic op_inverts_b(input op_t o);
    return (o == OP_SUB) || (o == OP_SBB);
  endfunction

  function automatic logic op_carry_in(input op_t o, input logic cin);
    logic c;
    case (o)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE_W-bit adder reporting carry out and carry into its MSB.
module adder_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);
  logic [SLICE_W:0] full;

  assign full = (SLICE_W+1)'(a) + (SLICE_W+1)'(b) + (SLICE_W+1)'(cin);
  assign sum  = full[SLICE_W-1:0];
  assign cout = full[SLICE_W];
  // The MSB sum bit is a^b^carry_in, so the carry into it can be recovered.
  assign c_msb = a[SLICE_W-1] ^ b[SLICE_W-1] ^ sum[SLICE_W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined WIDTH-bit add/subtract: one WIDTH/STAGES-bit slice per stage,
// valid/ready handshake with per-stage valid bits and full-throughput flow.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);
  localparam int SW = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;

  if (!(STAGES >= 1 && STAGES <= WIDTH && (WIDTH % ((STAGES >= 1) ? STAGES : 1)) == 0))
  begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  op_t op_e;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [STAGES-1:0] valid_q, valid_d, adv, ld;
  logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [STAGES-1:0] carry_q, carry_d, cmsb_q, cmsb_d;

  logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_res;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0][SW-1:0]    slice_sum;
  logic [STAGES-1:0]            slice_cout, slice_cmsb;

  assign op_e    = op_t'(op);
  assign b_eff   = op_inverts_b(op_e) ? ~b : b;
  assign cin_eff = op_carry_in(op_e, cin);

  // Walk from the output back: a stage may move when the one after it is free.
  always_comb begin
    logic free;
    adv     = '0;
    ld      = '0;
    valid_d = valid_q;
    free    = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = valid_q[i] && free;
      free   = !valid_q[i] || adv[i];
    end
    in_ready = free;
    ld[0]    = in_valid && in_ready;
    for (int i = 1; i < STAGES; i++) begin
      ld[i] = adv[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      valid_d[i] = ld[i] || (valid_q[i] && !adv[i]);
    end
  end

  always_comb begin
    src_a   = '0;
    src_b   = '0;
    src_res = '0;
    src_c   = '0;
    src_a[0] = a;
    src_b[0] = b_eff;
    src_c[0] = cin_eff;
    for (int i = 1; i < STAGES; i++) begin
      src_a[i]   = opa_q[i-1];
      src_b[i]   = opb_q[i-1];
      src_res[i] = res_q[i-1];
      src_c[i]   = carry_q[i-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    adder_slice #(.SLICE_W(SW)) u_slice (
      .a     (src_a[gi][gi*SW +: SW]),
      .b     (src_b[gi][gi*SW +: SW]),
      .cin   (src_c[gi]),
      .sum   (slice_sum[gi]),
      .cout  (slice_cout[gi]),
      .c_msb (slice_cmsb[gi])
    );
  end

  always_comb begin
    opa_d   = src_a;
    opb_d   = src_b;
    res_d   = src_res;
    carry_d = slice_cout;
    cmsb_d  = slice_cmsb;
    for (int i = 0; i < STAGES; i++) begin
      res_d[i][i*SW +: SW] = slice_sum[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (ld[i]) begin
        opa_q[i]   <= opa_d[i];
        opb_q[i]   <= opb_d[i];
        res_q[i]   <= res_d[i];
        carry_q[i] <= carry_d[i];
        cmsb_q[i]  <= cmsb_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Outputs are gated by the output-stage valid so they read zero in reset.
  assign out_valid = valid_q[STAGES-1];
  assign out       = out_valid ? res_q[STAGES-1] : '0;
  assign carry_out = out_valid && carry_q[STAGES-1];
  assign overflow  = out_valid && (carry_q[STAGES-1] ^ cmsb_q[STAGES-1]);

  logic unused_bits;
  assign unused_bits = ^{opa_q, opb_q, carry_q, cmsb_q};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: random and directed traffic, stalls,
// mid-flight reset, and latency of the 1- and 8-stage variants.
module tb_pipelined_adder;
  import adder_pkg::*;

  typedef struct {
    logic [63:0] sum;
    logic        c;
    logic        v;
    bit          chk_lat;
    longint      acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_valid1 = 1'b0, in_valid8 = 1'b0;
  logic in_ready, in_ready1, in_ready8;
  logic [63:0] a = '0, b = '0;
  logic [1:0]  op = 2'b00;
  logic        cin = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_valid1, out_valid8;
  logic [63:0] out, out1, out8;
  logic        carry_out, carry_out1, carry_out8;
  logic        overflow, overflow1, overflow8;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_txn = 0;
  longint cyc = 0;
  exp_t   sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder #(.WIDTH(64), .STAGES(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry_out(carry_out), .overflow(overflow));

  pipelined_adder #(.WIDTH(64), .STAGES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
    .out(out1), .carry_out(carry_out1), .overflow(overflow1));

  pipelined_adder #(.WIDTH(64), .STAGES(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid8), .out_ready(out_ready),
    .out(out8), .carry_out(carry_out8), .overflow(overflow8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [63:0] ta, input logic [63:0] tb_v,
                                 input logic [1:0] top, input logic tcin);
    exp_t e;
    logic [63:0] bb;
    logic [64:0] full;
    logic c0;
    bb = top[1] ? ~tb_v : tb_v;
    case (top)
      2'b00:   c0 = 1'b0;
      2'b10:   c0 = 1'b1;
      default: c0 = tcin;
    endcase
    full = {1'b0, ta} + {1'b0, bb} + {64'd0, c0};
    e.sum = full[63:0];
    e.c   = full[64];
    e.v   = (ta[63] == bb[63]) && (full[63] != ta[63]);
    e.chk_lat = 1'b0;
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] s, input logic c, input logic v);
    exp_t e;
    e.sum = s; e.c = c; e.v = v; e.chk_lat = 1'b1; e.acc = 0;
    return e;
  endfunction

  task automatic send_exp(input logic [63:0] ta, input logic [63:0] tb_v, input logic [1:0] top,
                          input logic tcin, input exp_t e, input bit chk_ready);
    int waited = 0;
    a = ta; b = tb_v; op = top; cin = tcin; in_valid = 1'b1;
    @(negedge clk);
    if (chk_ready) check("in_ready_flow", 64'(in_ready), 64'd1);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_ops(output logic [63:0] ta, output logic [63:0] tb_v,
                          output logic [1:0] top, output logic tcin);
    int sel;
    sel = int'($urandom_range(0, 3));
    ta = (sel == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (sel == 1) ? 64'h8000_0000_0000_0000
                                              : {$urandom, $urandom};
    tb_v = {$urandom, $urandom};
    top  = 2'($urandom_range(0, 3));
    tcin = 1'($urandom_range(0, 1));
  endtask

  task automatic send_rand(input bit chk_ready);
    logic [63:0] ta, tb_v;
    logic [1:0]  top;
    logic        tcin;
    rand_ops(ta, tb_v, top, tcin);
    send_exp(ta, tb_v, top, tcin, model(ta, tb_v, top, tcin), chk_ready);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic latency_test(input int sel, input int exp_lat);
    int lat;
    logic [63:0] o;
    logic oc, ov, ovld;
    a = 64'h0000_0000_FFFF_FFFF; b = 64'd0; op = OP_ADC; cin = 1'b1;
    if (sel == 1) in_valid1 = 1'b1; else in_valid8 = 1'b1;
    @(negedge clk);
    check($sformatf("s%0d_in_ready", sel), 64'((sel == 1) ? in_ready1 : in_ready8), 64'd1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0; in_valid8 = 1'b0;
    lat = 1;
    ovld = (sel == 1) ? out_valid1 : out_valid8;
    while (!ovld && lat <= 20) begin
      @(posedge clk);
      #1;
      lat++;
      ovld = (sel == 1) ? out_valid1 : out_valid8;
    end
    o  = (sel == 1) ? out1 : out8;
    oc = (sel == 1) ? carry_out1 : carry_out8;
    ov = (sel == 1) ? overflow1 : overflow8;
    check($sformatf("s%0d_latency", sel), 64'(lat), 64'(exp_lat));
    check($sformatf("s%0d_out", sel), o, 64'h0000_0001_0000_0000);
    check($sformatf("s%0d_carry", sel), 64'(oc), 64'd0);
    check($sformatf("s%0d_ovf", sel), 64'(ov), 64'd0);
    $display("txn s%0d out=%h lat=%0d", sel, o, lat);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output transfer; checks held value while stalled.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_output", 64'(out_valid), 64'd0);
      end else if (out_ready) begin
        exp_t e;
        e = sb.pop_front();
        n_txn++;
        check("out", out, e.sum);
        check("carry_out", 64'(carry_out), 64'(e.c));
        check("overflow", 64'(overflow), 64'(e.v));
        if (e.chk_lat) check("latency", 64'(cyc + 1 - e.acc), 64'd4);
        $display("txn %0d out=%h c=%b v=%b", n_txn, out, carry_out, overflow);
      end else begin
        check("held_out", out, sb[0].sum);
      end
    end
  end

  initial begin
    int accepted;
    #22;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", out, 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner cases, one at a time so latency is measurable.
    send_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0, mk_exp(64'd0, 1'b1, 1'b0), 1'b0);
    wait_drain();
    send_exp(64'h8000_0000_0000_0000, 64'd1, OP_SUB, 1'b0,
             mk_exp(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1), 1'b0);
    wait_drain();
    send_exp(64'd5, 64'd7, OP_SBB, 1'b0, mk_exp(64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0), 1'b0);
    wait_drain();

    // Back-to-back random flow with out_ready held high.
    for (int i = 0; i < 100; i++) send_rand(1'b1);
    wait_drain();

    // Stall the output for 10 cycles while offering input every cycle.
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      logic [63:0] ta, tb_v;
      logic [1:0]  top;
      logic        tcin;
      rand_ops(ta, tb_v, top, tcin);
      a = ta; b = tb_v; op = top; cin = tcin; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e = model(ta, tb_v, top, tcin);
        e.acc = cyc + 1;
        sb.push_back(e);
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_accepted", 64'(accepted), 64'd4);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_drain();

    // Reset with three tokens in flight.
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    @(posedge clk);
    #1;
    check("flight_out_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", out, 64'd0);
    check("midrst_carry", 64'(carry_out), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Traffic still flows correctly after the mid-flight reset.
    for (int i = 0; i < 8; i++) send_rand(1'b1);
    wait_drain();

    latency_test(1, 1);
    latency_test(8, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
